// File: rtl/loadq_ring_pkg.sv
// Shared load-queue definitions: entry states, ring pointer type, ROB age compare.
// Default sizing constants for loadq_ring live here too.
package mem_defs;

  localparam int LDQ_RING_NUM_ENTRIES = 16;
  localparam int LDQ_RING_ALLOC_LANES = 2;
  localparam int LDQ_RING_RET_LANES   = 2;
  localparam int LDQ_RING_ROBID_W     = 6;
  localparam int LDQ_RING_REPLAY_WAIT = 4;
  localparam int LDQ_RING_IDX_W       = $clog2(LDQ_RING_NUM_ENTRIES);

  typedef enum logic [2:0] {
    INVALID  = 3'd0,
    WAIT_ISS = 3'd1,
    READY    = 3'd2,
    IN_PIPE  = 3'd3,
    BACKOFF  = 3'd4,
    DONE     = 3'd5
  } t_ldq_state;

  typedef struct packed {
    logic                      wrap;
    logic [LDQ_RING_IDX_W-1:0] idx;
  } t_ldq_ptr;

  // True when ROB id a is the same as or older than b; bit w-1 is the wrap bit.
  function automatic logic robid_older_eq(input logic [31:0] a, input logic [31:0] b,
                                          input int w);
    logic [31:0] mask;
    mask = (32'd1 << (w - 1)) - 32'd1;
    if (a[w-1] == b[w-1]) return (a & mask) <= (b & mask);
    else                  return (a & mask) >  (b & mask);
  endfunction

endpackage

// File: rtl/loadq_ring_entry.sv
// One load-queue slot: lifecycle FSM, captured ROB id and replay back-off down-counter.
//   state    | meaning
//   INVALID  | slot free
//   WAIT_ISS | allocated, waiting for RS issue
//   READY    | requesting the mem pipe
//   IN_PIPE  | granted, waiting for the mm5 response
//   BACKOFF  | replayed, counting down before re-requesting
//   DONE     | completed, waiting for retire
module loadq_ring_entry
  import mem_defs::*;
#(
  parameter int ROBID_W     = LDQ_RING_ROBID_W,
  parameter int REPLAY_WAIT = LDQ_RING_REPLAY_WAIT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_alloc,
  input  logic [ROBID_W-1:0] i_alloc_robid,
  input  logic               i_kill,
  input  logic               i_iss,
  input  logic               i_gnt,
  input  logic               i_rsp,
  input  logic               i_rsp_replay,
  output t_ldq_state         o_state,
  output logic [ROBID_W-1:0] o_robid
);

  localparam int CW = $clog2(REPLAY_WAIT + 1);

  t_ldq_state         r_state;
  logic [ROBID_W-1:0] r_robid;
  logic [CW-1:0]      r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= INVALID;
      r_robid <= '0;
      r_cnt   <= '0;
    end else if (i_alloc) begin
      r_state <= WAIT_ISS;
      r_robid <= i_alloc_robid;
    end else if (i_kill) begin
      r_state <= INVALID;
    end else begin
      case (r_state)
        WAIT_ISS: if (i_iss) r_state <= READY;
        READY:    if (i_gnt) r_state <= IN_PIPE;
        IN_PIPE: begin
          if (i_rsp) begin
            if (i_rsp_replay) begin
              r_state <= BACKOFF;
              r_cnt   <= CW'(REPLAY_WAIT);
            end else begin
              r_state <= DONE;
            end
          end
        end
        // Leaving on the last count makes the re-request land REPLAY_WAIT+1 cycles after the rsp.
        BACKOFF: begin
          if (r_cnt <= CW'(1)) r_state <= READY;
          else                 r_cnt   <= r_cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_state = r_state;
  assign o_robid = r_robid;

endmodule

// File: rtl/loadq_ring.sv
// Age-ordered circular load queue with oldest-first mem pipe arbitration and ROB-id nuke.
// Optional replay statistic counter enabled by LOADQ_RING_STATS_EN.
module loadq_ring
  import mem_defs::*;
#(
  parameter  int NUM_ENTRIES = LDQ_RING_NUM_ENTRIES,
  parameter  int ALLOC_LANES = LDQ_RING_ALLOC_LANES,
  parameter  int RET_LANES   = LDQ_RING_RET_LANES,
  parameter  int ROBID_W     = LDQ_RING_ROBID_W,
  parameter  int REPLAY_WAIT = LDQ_RING_REPLAY_WAIT,
  localparam int IW          = $clog2(NUM_ENTRIES),
  localparam int PW          = IW + 1,
  localparam int RCW         = $clog2(RET_LANES) + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ALLOC_LANES-1:0]         alloc_valid,
  input  logic [ALLOC_LANES*ROBID_W-1:0] alloc_robid,
  output logic                           alloc_ready,
  output logic [ALLOC_LANES*IW-1:0]      alloc_ldqid,
  input  logic                           iss_valid,
  input  logic [IW-1:0]                  iss_ldqid,
  output logic                           pipe_req,
  output logic [IW-1:0]                  pipe_req_ldqid,
  output logic [ROBID_W-1:0]             pipe_req_robid,
  input  logic                           pipe_gnt,
  input  logic                           pipe_rsp_valid,
  input  logic [IW-1:0]                  pipe_rsp_ldqid,
  input  logic                           pipe_rsp_replay,
  input  logic [RCW-1:0]                 retire_cnt,
  input  logic                           nuke_valid,
  input  logic [ROBID_W-1:0]             nuke_robid,
  output logic [PW-1:0]                  count,
  output logic                           idle,
  output logic                           full,
  output logic [15:0]                    replay_cnt
);

  logic [PW-1:0]      r_head, r_tail;
  logic [PW-1:0]      w_count, w_free, w_nalloc, w_nflush;
  t_ldq_state         w_state [NUM_ENTRIES];
  logic [ROBID_W-1:0] w_robid [NUM_ENTRIES];
  logic [ROBID_W-1:0] w_alloc_rob [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] w_alloc_hit, w_ret_mask, w_flush, w_kill, w_iss, w_gnt, w_rsp;
  logic [IW-1:0]      w_slot, w_scan, w_sel;
  logic               w_found;

  assign w_count     = r_tail - r_head;
  assign w_free      = PW'(NUM_ENTRIES) - w_count;
  assign alloc_ready = int'(w_free) >= ALLOC_LANES;
  assign count       = w_count;
  assign idle        = (w_count == '0);
  assign full        = (w_count == PW'(NUM_ENTRIES));

  // Allocation: lane l lands at tail+l; the whole group is dropped in a nuke cycle.
  always_comb begin
    w_alloc_hit = '0;
    w_nalloc    = '0;
    w_slot      = '0;
    alloc_ldqid = '0;
    for (int e = 0; e < NUM_ENTRIES; e++) w_alloc_rob[e] = '0;
    for (int l = 0; l < ALLOC_LANES; l++) begin
      w_slot = r_tail[IW-1:0] + IW'(l);
      alloc_ldqid[l*IW +: IW] = w_slot;
      if (alloc_valid[l] && !nuke_valid) begin
        w_alloc_hit[w_slot] = 1'b1;
        w_alloc_rob[w_slot] = alloc_robid[l*ROBID_W +: ROBID_W];
        w_nalloc            = w_nalloc + PW'(1);
      end
    end
  end

  // Retire is applied first so the nuke only sees entries that survive it.
  always_comb begin
    w_ret_mask = '0;
    w_flush    = '0;
    w_nflush   = '0;
    for (int j = 0; j < RET_LANES; j++)
      if (RCW'(j) < retire_cnt) w_ret_mask[r_head[IW-1:0] + IW'(j)] = 1'b1;
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      w_flush[e] = nuke_valid && (w_state[e] != INVALID) && !w_ret_mask[e] &&
                   robid_older_eq(32'(nuke_robid), 32'(w_robid[e]), ROBID_W);
      w_nflush   = w_nflush + PW'(w_flush[e]);
    end
    w_kill = w_ret_mask | w_flush;
  end

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_scan  = '0;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      w_scan = r_head[IW-1:0] + IW'(k);
      if (!w_found && w_state[w_scan] == READY) begin
        w_found = 1'b1;
        w_sel   = w_scan;
      end
    end
  end

  assign pipe_req       = w_found;
  assign pipe_req_ldqid = w_sel;
  assign pipe_req_robid = w_robid[w_sel];

  always_comb begin
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      w_iss[e] = iss_valid && (iss_ldqid == IW'(e));
      w_gnt[e] = pipe_gnt && w_found && (w_sel == IW'(e));
      w_rsp[e] = pipe_rsp_valid && (pipe_rsp_ldqid == IW'(e));
    end
  end

  for (genvar e = 0; e < NUM_ENTRIES; e++) begin : g_ent
    loadq_ring_entry #(
      .ROBID_W    (ROBID_W),
      .REPLAY_WAIT(REPLAY_WAIT)
    ) u_ent (
      .clk          (clk),
      .reset        (reset),
      .i_alloc      (w_alloc_hit[e]),
      .i_alloc_robid(w_alloc_rob[e]),
      .i_kill       (w_kill[e]),
      .i_iss        (w_iss[e]),
      .i_gnt        (w_gnt[e]),
      .i_rsp        (w_rsp[e]),
      .i_rsp_replay (pipe_rsp_replay),
      .o_state      (w_state[e]),
      .o_robid      (w_robid[e])
    );
  end

  // Flushed entries are contiguous up to tail, so pulling tail back by their number suffices.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_head <= r_head + PW'(retire_cnt);
      if (nuke_valid) r_tail <= r_tail - w_nflush;
      else            r_tail <= r_tail + w_nalloc;
    end
  end

`ifdef LOADQ_RING_STATS_EN
  logic [15:0] r_replay_cnt;
  logic        w_replay_acc;
  assign w_replay_acc = pipe_rsp_valid && pipe_rsp_replay &&
                        (w_state[pipe_rsp_ldqid] == IN_PIPE) && !w_kill[pipe_rsp_ldqid];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                   r_replay_cnt <= '0;
    else if (w_replay_acc && r_replay_cnt != 16'hFFFF) r_replay_cnt <= r_replay_cnt + 16'd1;
  end
  assign replay_cnt = r_replay_cnt;
`else
  assign replay_cnt = '0;
`endif

  always @(posedge clk) begin
    if (reset) begin
      assert (!(|alloc_valid) || alloc_ready);
      assert (32'(retire_cnt) <= 32'(w_count));
      assert (32'(retire_cnt) <= RET_LANES);
      for (int e = 0; e < NUM_ENTRIES; e++)
        assert (!w_ret_mask[e] || w_state[e] == DONE);
    end
  end

endmodule

// File: tb/tb_loadq_ring.sv
// Directed bench for loadq_ring: scoreboarded alloc ids and mem pipe requests.
module tb_loadq_ring;

  localparam int N  = 16;
  localparam int L  = 2;
  localparam int RB = 6;
  localparam int IW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [L-1:0]    alloc_valid = '0;
  logic [L*RB-1:0] alloc_robid = '0;
  logic            alloc_ready;
  logic [L*IW-1:0] alloc_ldqid;
  logic            iss_valid = 1'b0;
  logic [IW-1:0]   iss_ldqid = '0;
  logic            pipe_req;
  logic [IW-1:0]   pipe_req_ldqid;
  logic [RB-1:0]   pipe_req_robid;
  logic            pipe_gnt = 1'b0;
  logic            pipe_rsp_valid = 1'b0;
  logic [IW-1:0]   pipe_rsp_ldqid = '0;
  logic            pipe_rsp_replay = 1'b0;
  logic [1:0]      retire_cnt = '0;
  logic            nuke_valid = 1'b0;
  logic [RB-1:0]   nuke_robid = '0;
  logic [IW:0]     count;
  logic            idle, full;
  logic [15:0]     replay_cnt;

  loadq_ring #(.NUM_ENTRIES(N), .ALLOC_LANES(L), .RET_LANES(2), .ROBID_W(RB), .REPLAY_WAIT(4))
  dut (
    .clk(clk), .reset(reset), .alloc_valid(alloc_valid), .alloc_robid(alloc_robid),
    .alloc_ready(alloc_ready), .alloc_ldqid(alloc_ldqid), .iss_valid(iss_valid),
    .iss_ldqid(iss_ldqid), .pipe_req(pipe_req), .pipe_req_ldqid(pipe_req_ldqid),
    .pipe_req_robid(pipe_req_robid), .pipe_gnt(pipe_gnt), .pipe_rsp_valid(pipe_rsp_valid),
    .pipe_rsp_ldqid(pipe_rsp_ldqid), .pipe_rsp_replay(pipe_rsp_replay),
    .retire_cnt(retire_cnt), .nuke_valid(nuke_valid), .nuke_robid(nuke_robid),
    .count(count), .idle(idle), .full(full), .replay_cnt(replay_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {int unsigned id; int unsigned rob;} t_exp;
  t_exp        req_q[$];
  int unsigned id_q[$];
  int total = 0;
  int bad   = 0;
  int m_head = 0;
  int m_tail = 0;

`ifdef LOADQ_RING_STATS_EN
  localparam int EXP_REPLAYS = 1;
`else
  localparam int EXP_REPLAYS = 0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input int unsigned id, input int unsigned rob);
    t_exp e;
    e.id  = id;
    e.rob = rob;
    req_q.push_back(e);
  endtask

  task automatic expect_req(input string tag);
    t_exp e;
    if (req_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=empty_scoreboard expected=queued_request", tag);
    end else begin
      e = req_q.pop_front();
      check({tag, "_v"},   32'(pipe_req), 32'd1);
      check({tag, "_id"},  32'(pipe_req_ldqid), e.id);
      check({tag, "_rob"}, 32'(pipe_req_robid), e.rob);
    end
  endtask

  task automatic check_count(input string tag);
    check(tag, 32'(count), 32'((m_tail - m_head) & 31));
  endtask

  // Two-lane alloc: expected ids pushed from the bench tail model, popped against alloc_ldqid.
  task automatic do_alloc(input int r0, input int r1);
    int unsigned e;
    check("alloc_ready", 32'(alloc_ready), 32'(((N - ((m_tail - m_head) & 31)) >= L) ? 1 : 0));
    for (int l = 0; l < L; l++) id_q.push_back(32'((m_tail + l) % N));
    for (int l = 0; l < L; l++) begin
      e = id_q.pop_front();
      check("alloc_id", 32'(alloc_ldqid[l*IW +: IW]), e);
    end
    alloc_valid = 2'b11;
    alloc_robid = {6'(r1), 6'(r0)};
    step();
    alloc_valid = '0;
    m_tail = (m_tail + L) & 31;
  endtask

  task automatic issue(input int id);
    iss_valid = 1'b1;
    iss_ldqid = 4'(id);
    step();
    iss_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_count", 32'(count), 0);
    check("rst_idle", 32'(idle), 1);
    check("rst_full", 32'(full), 0);
    check("rst_ready", 32'(alloc_ready), 1);
    check("rst_req", 32'(pipe_req), 0);
    check("rst_replay", 32'(replay_cnt), 0);
    step();
    reset = 1'b1;
    step();

    // Fill: ids 0..15 in order, entry i gets robid i.
    for (int c = 0; c < 8; c++) do_alloc(2 * c, 2 * c + 1);
    check("fill_full", 32'(full), 1);
    check("fill_ready", 32'(alloc_ready), 0);
    check_count("fill_count");

    // Issue 5 then 2: 5 requests the cycle after its issue, then 2 wins as the older.
    push_req(5, 5);
    issue(5);
    expect_req("iss5");
    push_req(2, 2);
    push_req(5, 5);
    issue(2);
    expect_req("old2");
    pipe_gnt = 1'b1;
    step();
    expect_req("then5");
    step();
    pipe_gnt = 1'b0;
    check("arb_empty", 32'(pipe_req), 0);

    // Replay entry 3: quiet for 4 cycles, request again on the 5th after the rsp.
    push_req(3, 3);
    issue(3);
    expect_req("iss3");
    pipe_gnt = 1'b1;
    step();
    pipe_gnt = 1'b0;
    pipe_rsp_valid = 1'b1;
    pipe_rsp_ldqid = 4'd3;
    pipe_rsp_replay = 1'b1;
    step();
    pipe_rsp_valid = 1'b0;
    pipe_rsp_replay = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check("backoff_quiet", 32'(pipe_req), 0);
      step();
    end
    push_req(3, 3);
    expect_req("replay3");
    check("replay_cnt", 32'(replay_cnt), EXP_REPLAYS);
    pipe_gnt = 1'b1;
    step();
    pipe_gnt = 1'b0;

    for (int i = 0; i < N; i++) begin
      if (i != 2 && i != 3 && i != 5) begin
        push_req(i, i);
        issue(i);
        expect_req("iss_all");
        pipe_gnt = 1'b1;
        step();
        pipe_gnt = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      pipe_rsp_valid = 1'b1;
      pipe_rsp_ldqid = 4'(i);
      step();
    end
    pipe_rsp_valid = 1'b0;

    for (int k = 0; k < 7; k++) begin
      retire_cnt = 2'd2;
      step();
      m_head = (m_head + 2) & 31;
    end
    retire_cnt = '0;
    check_count("ret14_count");
    check("ret14_full", 32'(full), 0);

    // Wrap: entries 0..3 get robids 16..19, head=14, tail=4 with wrap set.
    do_alloc(16, 17);
    do_alloc(18, 19);
    check_count("wrap_count");
    check("wrap_count6", 32'(count), 6);

    nuke_valid = 1'b1;
    nuke_robid = 6'd17;
    step();
    nuke_valid = 1'b0;
    check("nuke_count", 32'(count), 3);
    check("nuke_tail", 32'(alloc_ldqid[IW-1:0]), 1);
    m_tail = 17;
    issue(1);
    check("nuke_stale_iss", 32'(pipe_req), 0);

    // Retire + nuke + alloc in one cycle.
    do_alloc(20, 21);
    check_count("pre_mix_count");
    retire_cnt = 2'd2;
    nuke_valid = 1'b1;
    nuke_robid = 6'd20;
    alloc_valid = 2'b11;
    alloc_robid = {6'd31, 6'd30};
    step();
    retire_cnt = '0;
    nuke_valid = 1'b0;
    alloc_valid = '0;
    m_head = 16;
    m_tail = 17;
    check_count("mix_count");
    check("mix_tail0", 32'(alloc_ldqid[IW-1:0]), 1);
    check("mix_tail1", 32'(alloc_ldqid[2*IW-1:IW]), 2);
    issue(1);
    check("mix_no_alloc", 32'(pipe_req), 0);

    // Async reset with entry 0 in the pipe, then a stale replay rsp.
    push_req(0, 16);
    issue(0);
    expect_req("iss0");
    pipe_gnt = 1'b1;
    step();
    pipe_gnt = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_idle", 32'(idle), 1);
    check("arst_full", 32'(full), 0);
    check("arst_ready", 32'(alloc_ready), 1);
    check("arst_req", 32'(pipe_req), 0);
    check("arst_replay", 32'(replay_cnt), 0);
    check("arst_id0", 32'(alloc_ldqid[IW-1:0]), 0);
    step();
    step();
    reset = 1'b1;
    step();
    pipe_rsp_valid = 1'b1;
    pipe_rsp_ldqid = 4'd0;
    pipe_rsp_replay = 1'b1;
    step();
    pipe_rsp_valid = 1'b0;
    pipe_rsp_replay = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("stale_rsp_req", 32'(pipe_req), 0);
      step();
    end
    check("stale_rsp_replay", 32'(replay_cnt), 0);
    check("stale_rsp_idle", 32'(idle), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
